// File: rtl/beu_clmul_pkg.sv
// Shared types for the iterative carry-less multiplier: operation variants and FSM states.
package beu_clmul_pkg;

    typedef enum logic [1:0] {
        CLMUL_L = 2'b00,
        CLMUL_H = 2'b01,
        CLMUL_R = 2'b10
    } clmul_mode_t;

    typedef enum logic [1:0] {
        CM_IDLE = 2'b00,
        CM_BUSY = 2'b01,
        CM_DONE = 2'b10
    } clmul_state_t;

endpackage

// File: rtl/beu_clmul_step.sv
// One iteration of the carry-less multiply: folds BPC partial products into the running product.
module beu_clmul_step #(
    parameter int XLEN = 32,
    parameter int BPC  = 1
) (
    input  logic [2*XLEN-2:0] product,
    input  logic [2*XLEN-2:0] operand,
    input  logic [BPC-1:0]    bits,
    output logic [2*XLEN-2:0] next_product
);

    // Shifts happen at full product width, so bits pushed past the top are dropped.
    always_comb begin
        next_product = product;
        for (int j = 0; j < BPC; j++) begin
            if (bits[j]) begin
                next_product = next_product ^ (operand << j);
            end
        end
    end

endmodule

// File: rtl/beu_clmul.sv
// Iterative CLMUL/CLMULH/CLMULR unit with early exit and a valid/stall/flush handshake for EX.
module beu_clmul
    import beu_clmul_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int BPC        = 1,
    parameter int EARLY_EXIT = 1
) (
    input  logic            s_clk_i,
    input  logic            s_reset_i,
    input  logic            s_start_i,
    input  logic [1:0]      s_mode_i,
    input  logic [XLEN-1:0] s_op1_i,
    input  logic [XLEN-1:0] s_op2_i,
    input  logic            s_stall_i,
    input  logic            s_flush_i,
    output logic            s_ready_o,
    output logic            s_valid_o,
    output logic [XLEN-1:0] s_result_o
);

    localparam int W  = 2*XLEN - 1;
    localparam int N  = XLEN / BPC;
    localparam int CW = $clog2(N + 1);

    clmul_state_t    state_q, state_d;
    logic [W-1:0]    product_q, product_d;
    logic [W-1:0]    operand_q, operand_d;
    logic [XLEN-1:0] consume_q, consume_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      mode_q, mode_d;
    logic [W-1:0]    step_product;

    beu_clmul_step #(
        .XLEN (XLEN),
        .BPC  (BPC)
    ) u_step (
        .product      (product_q),
        .operand      (operand_q),
        .bits         (consume_q[BPC-1:0]),
        .next_product (step_product)
    );

    // NOTE: every signal gets its hold value before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        product_d = product_q;
        operand_d = operand_q;
        consume_d = consume_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;

        if (s_flush_i) begin
            state_d = CM_IDLE;
        end else begin
            case (state_q)
                CM_IDLE: begin
                    if (s_start_i) begin
                        mode_d    = s_mode_i;
                        product_d = '0;
                        operand_d = {{(XLEN-1){1'b0}}, s_op2_i};
                        consume_d = s_op1_i;
                        cnt_d     = '0;
                        state_d   = (s_op1_i == '0 || s_op2_i == '0) ? CM_DONE : CM_BUSY;
                    end
                end
                CM_BUSY: begin
                    product_d = step_product;
                    operand_d = operand_q << BPC;
                    consume_d = consume_q >> BPC;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1) || (EARLY_EXIT != 0 && consume_d == '0)) begin
                        state_d = CM_DONE;
                    end
                end
                CM_DONE: begin
                    if (!s_stall_i) begin
                        state_d = CM_IDLE;
                    end
                end
                default: state_d = CM_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge s_clk_i or posedge s_reset_i) begin : CM_STATE
        if (s_reset_i) begin
            state_q <= CM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge s_clk_i or posedge s_reset_i) begin : CM_DATA
        if (s_reset_i) begin
            product_q <= '0;
            operand_q <= '0;
            consume_q <= '0;
            cnt_q     <= '0;
            mode_q    <= '0;
        end else begin
            product_q <= product_d;
            operand_q <= operand_d;
            consume_q <= consume_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
        end
    end

    assign s_ready_o = (state_q == CM_IDLE);
    assign s_valid_o = (state_q == CM_DONE);

    always_comb begin
        s_result_o = '0;
        if (s_valid_o) begin
            case (mode_q)
                CLMUL_L: s_result_o = product_q[XLEN-1:0];
                CLMUL_H: s_result_o = {1'b0, product_q[W-1:XLEN]};
                CLMUL_R: s_result_o = product_q[W-1:XLEN-1];
                default: s_result_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_beu_clmul.sv
// Directed and table-driven checks of beu_clmul across BPC and EARLY_EXIT configurations.
module tb_beu_clmul;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  start_v;
    logic [1:0]  mode;
    logic [31:0] op1, op2;
    logic        stall, flush;
    logic        ready_v [4];
    logic        valid_v [4];
    logic [31:0] result_v [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Instance 0: BPC=1; 1: BPC=4; 2: BPC=8; 3: BPC=1 without early exit.
    beu_clmul #(.XLEN(32), .BPC(1), .EARLY_EXIT(1)) dut0 (
        .s_clk_i(clk), .s_reset_i(rst), .s_start_i(start_v[0]), .s_mode_i(mode),
        .s_op1_i(op1), .s_op2_i(op2), .s_stall_i(stall), .s_flush_i(flush),
        .s_ready_o(ready_v[0]), .s_valid_o(valid_v[0]), .s_result_o(result_v[0]));
    beu_clmul #(.XLEN(32), .BPC(4), .EARLY_EXIT(1)) dut1 (
        .s_clk_i(clk), .s_reset_i(rst), .s_start_i(start_v[1]), .s_mode_i(mode),
        .s_op1_i(op1), .s_op2_i(op2), .s_stall_i(stall), .s_flush_i(flush),
        .s_ready_o(ready_v[1]), .s_valid_o(valid_v[1]), .s_result_o(result_v[1]));
    beu_clmul #(.XLEN(32), .BPC(8), .EARLY_EXIT(1)) dut2 (
        .s_clk_i(clk), .s_reset_i(rst), .s_start_i(start_v[2]), .s_mode_i(mode),
        .s_op1_i(op1), .s_op2_i(op2), .s_stall_i(stall), .s_flush_i(flush),
        .s_ready_o(ready_v[2]), .s_valid_o(valid_v[2]), .s_result_o(result_v[2]));
    beu_clmul #(.XLEN(32), .BPC(1), .EARLY_EXIT(0)) dut3 (
        .s_clk_i(clk), .s_reset_i(rst), .s_start_i(start_v[3]), .s_mode_i(mode),
        .s_op1_i(op1), .s_op2_i(op2), .s_stall_i(stall), .s_flush_i(flush),
        .s_ready_o(ready_v[3]), .s_valid_o(valid_v[3]), .s_result_o(result_v[3]));

    typedef struct {
        int          idx;
        logic [1:0]  mode;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Bit-serial reference, independent of BPC.
    function automatic logic [31:0] ref_clmul(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] m);
        logic [62:0] p;
        p = '0;
        for (int i = 0; i < 32; i++) begin
            if (a[i]) p = p ^ ({31'b0, b} << i);
        end
        case (m)
            2'b00:   return p[31:0];
            2'b01:   return {1'b0, p[62:32]};
            2'b10:   return p[62:31];
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_lat(input int idx, input logic [31:0] a, input logic [31:0] b);
        int bpc;
        int msb;
        bpc = (idx == 1) ? 4 : (idx == 2) ? 8 : 1;
        if (a == 0 || b == 0) return 1;
        if (idx == 3) return 32 / bpc + 1;
        msb = 0;
        for (int i = 0; i < 32; i++) if (a[i]) msb = i;
        return (msb + bpc) / bpc + 1;
    endfunction

    // Called half a cycle after an edge with the target instance idle; returns there.
    task automatic do_op(input int idx, input logic [1:0] m, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] res, output int lat);
        mode = m;
        op1  = a;
        op2  = b;
        start_v[idx] = 1'b1;
        @(posedge clk); #1;
        start_v[idx] = 1'b0;
        lat = 1;
        while (!valid_v[idx] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result_v[idx];
        @(posedge clk); #1;
        check($sformatf("ready_after_op%0d", idx), 32'(ready_v[idx]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] res;
        int          lat;
        logic [31:0] ra, rb;
        logic [1:0]  rm;
        bit          seen;
        bit          hold_ok;

        rst = 1'b1; start_v = '0; mode = '0; op1 = '0; op2 = '0; stall = 1'b0; flush = 1'b0;

        vecs.push_back('{0, 2'b00, 32'h3,        32'h3,        32'h00000005, 3});
        vecs.push_back('{0, 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 33});
        vecs.push_back('{0, 2'b10, 32'h80000000, 32'h80000000, 32'h80000000, 33});
        vecs.push_back('{0, 2'b00, 32'h80000000, 32'h80000000, 32'h00000000, 33});
        vecs.push_back('{1, 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 9});
        vecs.push_back('{2, 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 5});
        vecs.push_back('{0, 2'b00, 32'h0,        32'h1234,     32'h00000000, 1});
        vecs.push_back('{0, 2'b00, 32'h5,        32'h0,        32'h00000000, 1});
        vecs.push_back('{3, 2'b00, 32'h1,        32'h12345678, 32'h12345678, 33});
        vecs.push_back('{0, 2'b11, 32'h3,        32'h3,        32'h00000000, 3});
        vecs.push_back('{0, 2'b00, 32'h1,        32'hFFFFFFFF, 32'hFFFFFFFF, 2});
        vecs.push_back('{1, 2'b00, 32'h5,        32'h3,        32'h0000000F, 2});
        vecs.push_back('{2, 2'b00, 32'hF,        32'hFF,       32'h00000505, 2});
        vecs.push_back('{0, 2'b10, 32'h3,        32'h80000000, 32'h00000003, 3});
        vecs.push_back('{0, 2'b01, 32'h3,        32'h80000000, 32'h00000001, 3});

        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        check("reset_ready", 32'(ready_v[0]), 32'd1);
        check("reset_valid", 32'(valid_v[0]), 32'd0);
        check("reset_result", result_v[0], 32'h0);

        foreach (vecs[i]) begin
            do_op(vecs[i].idx, vecs[i].mode, vecs[i].op1, vecs[i].op2, res, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].res);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Stall holds DONE; a start while BUSY is ignored.
        stall = 1'b1;
        mode = 2'b00; op1 = 32'h3; op2 = 32'h3; start_v[0] = 1'b1;
        @(posedge clk); #1;
        mode = 2'b01; op1 = 32'h0; op2 = 32'h0;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        lat = 2;
        while (!valid_v[0] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("busy_start_ignored_lat", 32'(lat), 32'd3);
        hold_ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (!valid_v[0] || result_v[0] !== 32'h5) hold_ok = 1'b0;
            @(posedge clk); #1;
        end
        check("stall_hold_result", result_v[0], 32'h5);
        check("stall_hold_steady", 32'(hold_ok), 32'd1);
        stall = 1'b0;
        @(posedge clk); #1;
        check("stall_release_ready", 32'(ready_v[0]), 32'd1);
        check("stall_release_valid", 32'(valid_v[0]), 32'd0);

        // Flush in BUSY.
        mode = 2'b00; op1 = 32'hFFFFFFFF; op2 = 32'h1; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (valid_v[0]) seen = 1'b1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_ready", 32'(ready_v[0]), 32'd1);
        check("flush_no_valid", 32'(seen | valid_v[0]), 32'd0);

        // Start coinciding with flush is dropped.
        op1 = 32'h3; op2 = 32'h3; start_v[0] = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0; flush = 1'b0;
        check("flush_drops_start", 32'(ready_v[0]), 32'd1);

        do_op(0, 2'b00, 32'hFFFFFFFF, 32'h1, res, lat);
        check("after_flush_result", res, 32'hFFFFFFFF);
        check("after_flush_latency", 32'(lat), 32'd33);

        // Asynchronous reset mid-BUSY.
        mode = 2'b00; op1 = 32'hFFFFFFFF; op2 = 32'h1; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_reset_ready", 32'(ready_v[0]), 32'd1);
        check("async_reset_valid", 32'(valid_v[0]), 32'd0);
        #4 rst = 1'b0;
        @(posedge clk); #1;

        // Random regression against the bit-serial model on every configuration.
        for (int idx = 0; idx < 4; idx++) begin
            for (int n = 0; n < 8; n++) begin
                ra = $urandom >> $urandom_range(0, 31);
                rb = $urandom;
                if ($urandom_range(0, 7) == 0) rb = 32'h0;
                rm = 2'($urandom_range(0, 3));
                do_op(idx, rm, ra, rb, res, lat);
                check($sformatf("rand%0d_%0d_result", idx, n), res, ref_clmul(ra, rb, rm));
                check($sformatf("rand%0d_%0d_latency", idx, n), 32'(lat), 32'(ref_lat(idx, ra, rb)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/beu_clmul.md
# beu_clmul

Parametrised, iterative carry-less multiplier for the bit-manipulation execution unit. It supports the full-width CLMUL/CLMULH/CLMULR variants with a configurable operand width and a configurable number of multiplier bits consumed per cycle. Early termination ends the computation as soon as the remaining multiplier is zero. A valid/stall/flush protocol lets it sit in the EX stage next to the combinational bit-manipulation logic and hold its result while MA is not ready.

## Interface
- XLEN, 32, operand width; ≥ 8, power of two.
- BPC, 1, multiplier bits consumed per cycle; power of two, 1..8, divides XLEN.
- EARLY_EXIT, 1, 1 = finish when the remaining multiplier is zero; 0 = always run all N = XLEN/BPC iterations.
- s_clk_i  in  1  clock.
- s_reset_i  in  1  asynchronous, active-high reset.
- s_start_i  in  1  request a new multiplication; honoured only when s_ready_o = 1.
- s_mode_i  in  2  clmul_mode_t, latched at accept.
- s_op1_i  in  XLEN  multiplier (consumed operand), latched at accept.
- s_op2_i  in  XLEN  multiplicand (shifted operand), latched at accept.
- s_stall_i  in  1  downstream not ready; holds DONE.
- s_flush_i  in  1  abort; highest priority after reset.
- s_ready_o  out  1  high in IDLE only.
- s_valid_o  out  1  high in DONE only.
- s_result_o  out  XLEN  selected result while s_valid_o = 1; 0 otherwise.

## Operation
- FSM states: IDLE, BUSY, DONE. Internal registers:
  - product, 2·XLEN−1 bits
  - operand, 2·XLEN−1 bits
  - consume, XLEN bits
  - cnt, $clog2(N+1) bits
  - mode
- IDLE → BUSY on s_start_i & ~s_flush_i. At accept:
  - product = 0, operand = op2, consume = op1, cnt = 0, mode latched.
  - If op1 == 0 or op2 == 0, go to DONE instead of BUSY, with product = 0.
- BUSY, one iteration per cycle:
  - product ^= XOR over j < BPC of (consume[j] ? operand << j : 0)
  - operand <<= BPC, consume >>= BPC, cnt++
- BUSY → DONE when cnt+1 == N, or when EARLY_EXIT and the shifted consume == 0. Otherwise stay in BUSY.
- DONE → IDLE when ~s_stall_i. DONE holds all registers while s_stall_i = 1.
- s_flush_i in any state: → IDLE next edge, s_valid_o low; a start presented in the same cycle is dropped.
- s_start_i outside IDLE is ignored. s_stall_i has no effect in IDLE or BUSY.
- Result selection, p = product:
  - CLMUL: p[XLEN-1:0]
  - CLMULH: {1'b0, p[2XLEN-2:XLEN]}
  - CLMULR: p[2XLEN-2:XLEN-1]
  - Reserved mode 2'b11: result 0, same timing.
- All arithmetic is modulo-2. Operand bits shifted beyond bit 2XLEN-2 are discarded.

## Timing
- Reset values: state IDLE; s_ready_o = 1, s_valid_o = 0, s_result_o = 0; all registers 0. Asserting reset mid-operation returns to IDLE asynchronously.
- Accept at edge t. Zero operand: s_valid_o at t+1.
- Otherwise s_valid_o at t+1+k.
  - With EARLY_EXIT = 1: k = ceil((msb_index(op1)+1)/BPC).
  - With EARLY_EXIT = 0: k = N.
- Worst case: XLEN/BPC + 1 cycles.
- s_result_o is combinational from the product and mode registers, gated by s_valid_o. It is stable for the whole time s_valid_o is high.
- Back-to-back: the earliest next accept is one cycle after DONE exits, i.e. the cycle with s_ready_o = 1.

## Structure
- p_hardisc gains typedef enum clmul_mode_t: CLMUL_L = 2'b00, CLMUL_H = 2'b01, CLMUL_R = 2'b10.
- p_hardisc gains a state typedef for IDLE/BUSY/DONE.
- Sub-module clmul_step (combinational, parameters XLEN and BPC): takes product, operand and consume slice, and returns the next product.
- State registers use the team's SEU-protected flip-flop wrappers, with labels prefixed "CM_".

## Test plan
- XLEN=32, BPC=1, mode CLMUL, op1=0x3, op2=0x3 → s_valid_o at t+3, result 0x00000005.
- op1=op2=0x80000000, BPC=1:
  - CLMULH → 0x40000000, valid at t+33.
  - CLMULR → 0x80000000.
  - CLMUL → 0x00000000.
- Latency sweep with op1=0x80000000:
  - BPC=4 → valid at t+9.
  - BPC=8 → valid at t+5.
  - op1=0 → valid at t+1, result 0.
  - EARLY_EXIT=0 with op1=1, BPC=1 → valid at t+33.
- Hold s_stall_i = 1 for 5 cycles in DONE → result and s_valid_o unchanged. Deassert → IDLE next cycle, s_ready_o = 1. A start issued while BUSY is ignored.
- s_flush_i in BUSY at cycle t+4 → IDLE at t+5, valid never asserted. A new start at t+5 completes with the correct result, 0xFFFFFFFF·0x1 → 0xFFFFFFFF.
- Reset asserted asynchronously mid-BUSY → s_valid_o = 0, s_ready_o = 1 immediately. Random regression against a bit-serial reference model for all modes and BPC values.
